// File: rtl/alu_seq_pkg.sv
// Shared state encodings and ALU opcode constants for the operand/opcode entry sequencer.
// Imported by alu_op_sequencer and its testbench.
package alu_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_e;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/button_conditioner.sv
// Purpose: turn the raw asynchronous "next" button into a single-cycle next_pulse (optional debounce via ALU_DEBOUNCE_EN).
// Latency: pulse is consumed on the 3rd edge after first high sample (DEBOUNCE_CYCLES+3 with debounce).
// Backpressure: none; a held button yields one pulse, a release and new press is needed for another.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_button,
   output logic next_pulse
);

   logic sync1;
   logic sync2;
   logic level;
   logic level_d;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync1   <= i_button;
         sync2   <= sync1;
         level_d <= level;
      end
   end

`ifdef ALU_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [DB_W-1:0] db_cnt;

   // Press accepted on the DEBOUNCE_CYCLES-th consecutive high sample; any low drops it at once.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (!sync2) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (!level) begin
         if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= 1'b1;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_db;

   assign unused_db = (DEBOUNCE_CYCLES == 0);
   assign level     = sync2;
`endif

   assign next_pulse = level & ~level_d;

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: single-button FSM loading A, B and opcode from switches into the ALU, then latching result/flags onto LEDs.
// Latency: result latched RES_LAT edges after the opcode capture edge; button path per button_conditioner (ALU_DEBOUNCE_EN).
// Backpressure: none; presses during EXEC are dropped, outputs hold until the next capture.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N_SW            = 8,
   parameter int N_OPERANDS      = 8,
   parameter int N_OP            = 6,
   parameter int RES_LAT         = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [N_SW-1:0]       i_sw,
   input  logic                  i_button_next,
   input  logic [N_OPERANDS-1:0] i_alu_Result,
   input  logic                  i_alu_ovf,
   input  logic                  i_alu_zero,
   output logic [N_OPERANDS-1:0] o_alu_A,
   output logic [N_OPERANDS-1:0] o_alu_B,
   output logic [N_OP-1:0]       o_alu_Op,
   output logic [N_OPERANDS+1:0] o_leds,
   output logic                  o_valid,
   output logic [2:0]            o_state
);

   localparam int LAT_W = (RES_LAT > 1) ? $clog2(RES_LAT + 1) : 1;

   logic             next_pulse;
   state_e           state;
   state_e           state_nxt;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_cnt_nxt;
   logic             cap_a;
   logic             cap_b;
   logic             cap_op;
   logic             cap_res;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_button (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_button  (i_button_next),
      .next_pulse(next_pulse)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state   <= LOAD_A;
         lat_cnt <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      cap_a       = 1'b0;
      cap_b       = 1'b0;
      cap_op      = 1'b0;
      cap_res     = 1'b0;
      case (state)
         LOAD_A: begin
            if (next_pulse) begin
               cap_a     = 1'b1;
               state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            if (next_pulse) begin
               cap_b     = 1'b1;
               state_nxt = LOAD_OP;
            end
         end
         LOAD_OP: begin
            if (next_pulse) begin
               cap_op      = 1'b1;
               lat_cnt_nxt = LAT_W'(RES_LAT);
               state_nxt   = EXEC;
            end
         end
         EXEC: begin
            // The edge taking the count from 1 to 0 is the one where the ALU result is valid.
            if (lat_cnt <= LAT_W'(1)) begin
               cap_res     = 1'b1;
               lat_cnt_nxt = '0;
               state_nxt   = SHOW;
            end else begin
               lat_cnt_nxt = lat_cnt - 1'b1;
            end
         end
         SHOW: begin
            if (next_pulse) begin
               state_nxt = LOAD_A;
            end
         end
         default: begin
            state_nxt = LOAD_A;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_alu_A  <= '0;
         o_alu_B  <= '0;
         o_alu_Op <= '0;
         o_leds   <= '0;
      end else begin
         if (cap_a) begin
            o_alu_A <= i_sw[N_OPERANDS-1:0];
         end
         if (cap_b) begin
            o_alu_B <= i_sw[N_OPERANDS-1:0];
         end
         if (cap_op) begin
            o_alu_Op <= i_sw[N_OP-1:0];
         end
         if (cap_res) begin
            o_leds <= {i_alu_zero, i_alu_ovf, i_alu_Result};
         end
      end
   end

   assign o_valid = (state == SHOW);
   assign o_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the bench plays the ALU with hand-chosen results.
// Debounce vectors are compiled in when ALU_DEBOUNCE_EN is defined.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int RES_LAT = 5;
   localparam int DB      = 8;
`ifdef ALU_DEBOUNCE_EN
   localparam int PRESS_LAT = DB + 3;
`else
   localparam int PRESS_LAT = 3;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] sw;
   logic       btn;
   logic [7:0] alu_res;
   logic       alu_ovf;
   logic       alu_zero;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [9:0] leds;
   logic       valid;
   logic [2:0] state;

   int err_cnt = 0;
   int chk_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer #(
      .N_SW           (8),
      .N_OPERANDS     (8),
      .N_OP           (6),
      .RES_LAT        (RES_LAT),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_sw         (sw),
      .i_button_next(btn),
      .i_alu_Result (alu_res),
      .i_alu_ovf    (alu_ovf),
      .i_alu_zero   (alu_zero),
      .o_alu_A      (alu_a),
      .o_alu_B      (alu_b),
      .o_alu_Op     (alu_op),
      .o_leds       (leds),
      .o_valid      (valid),
      .o_state      (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Hold the button exactly long enough for one advance, then let go.
   task automatic press(input logic [7:0] val);
      sw  = val;
      btn = 1'b1;
      repeat (PRESS_LAT) tick();
      btn = 1'b0;
   endtask

   task automatic release_wait();
      repeat (4) tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      btn      = 1'b0;
      sw       = 8'h00;
      alu_res  = 8'h00;
      alu_ovf  = 1'b0;
      alu_zero = 1'b0;
      repeat (2) tick();
      chk("rst_state", state, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_op", alu_op, 0);
      chk("rst_leds", leds, 0);
      chk("rst_valid", valid, 0);
      rst_n = 1'b1;
      tick();

      // ADD 5 + 3, with exact button latency check on the first press
      sw  = 8'h05;
      btn = 1'b1;
      repeat (PRESS_LAT - 1) tick();
      chk("lat_before", state, 0);
      tick();
      chk("lat_at", state, 1);
      chk("add_a", alu_a, 8'h05);
      btn = 1'b0;
      release_wait();
      press(8'h03);
      chk("add_b", alu_b, 8'h03);
      chk("add_st_opload", state, 2);
      release_wait();
      alu_res = 8'h08;
      press({2'b00, OP_ADD});
      chk("add_op", alu_op, 6'b100000);
      chk("add_st_exec", state, 3);
      for (int i = 1; i < RES_LAT; i++) tick();
      chk("add_exec_wait", state, 3);
      chk("add_leds_pre", leds, 0);
      tick();
      chk("add_st_show", state, 4);
      chk("add_leds", leds, 10'h008);
      chk("add_valid", valid, 1);
      press(8'h00);
      chk("show_exit_st", state, 0);
      chk("show_exit_valid", valid, 0);
      chk("show_exit_leds", leds, 10'h008);
      chk("show_exit_a", alu_a, 8'h05);
      release_wait();

      // SUB 0x0F - 0x0F: zero flag set
      press(8'h0F);
      release_wait();
      press(8'h0F);
      release_wait();
      alu_res  = 8'h00;
      alu_zero = 1'b1;
      press({2'b00, OP_SUB});
      chk("sub_op", alu_op, 6'b100010);
      repeat (RES_LAT) tick();
      chk("sub_leds", leds, 10'h200);
      chk("sub_st", state, 4);
      alu_zero = 1'b0;
      release_wait();
      press(8'h00);
      release_wait();

      // Held button: one advance only
      sw  = 8'h33;
      btn = 1'b1;
      repeat (50) tick();
      chk("held_st", state, 1);
      btn = 1'b0;
      release_wait();
      chk("held_after_rel", state, 1);
      press(8'h11);
      chk("held_second", state, 2);
      chk("held_b", alu_b, 8'h11);
      release_wait();

      // Press during EXEC is ignored; SHOW exactly RES_LAT edges after capture
      alu_res = 8'h42;
      press({2'b00, OP_AND});
      tick();
      btn = 1'b1;
      repeat (RES_LAT - 2) tick();
      chk("exec_ignore", state, 3);
      tick();
      chk("exec_show", state, 4);
      chk("exec_leds", leds, 10'h042);
      btn = 1'b0;
      release_wait();
      chk("exec_no_extra", state, 4);
      press(8'h00);
      chk("exec_back", state, 0);
      release_wait();

      // Reset mid-EXEC: nothing latched, then full sequence recovers
      press(8'h7F);
      release_wait();
      press(8'h01);
      release_wait();
      alu_res = 8'h80;
      alu_ovf = 1'b1;
      press({2'b00, OP_ADD});
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_st", state, 0);
      chk("mid_rst_a", alu_a, 0);
      chk("mid_rst_b", alu_b, 0);
      chk("mid_rst_op", alu_op, 0);
      chk("mid_rst_leds", leds, 0);
      chk("mid_rst_valid", valid, 0);
      repeat (RES_LAT + 2) tick();
      chk("mid_rst_idle", state, 0);
      chk("mid_rst_nolatch", leds, 0);
      press(8'h7F);
      release_wait();
      press(8'h01);
      release_wait();
      press({2'b00, OP_ADD});
      repeat (RES_LAT) tick();
      chk("recov_st", state, 4);
      chk("recov_leds", leds, 10'h180);
      chk("recov_a", alu_a, 8'h7F);
      release_wait();
      press(8'h00);
      release_wait();

`ifdef ALU_DEBOUNCE_EN
      // Short glitch rejected; 10-cycle press advances on edge DB+3
      btn = 1'b1;
      repeat (5) tick();
      btn = 1'b0;
      repeat (15) tick();
      chk("db_glitch", state, 0);
      sw  = 8'h09;
      btn = 1'b1;
      repeat (10) tick();
      btn = 1'b0;
      chk("db_edge10", state, 0);
      tick();
      chk("db_edge11", state, 1);
      chk("db_a", alu_a, 8'h09);
      release_wait();
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
